// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues icache line reads ahead of dispatch, buffers lines
// with their fetch PC, and hands out one 32-bit instruction per cycle.
module ifetch_queue #(
  parameter int W_DATA = 128,
  parameter int W_ADDR = 32,
  parameter int W_INSTR = 32,
  parameter int DEPTH = 4,
  parameter logic [W_ADDR-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [W_ADDR-1:0] icache_pcout,
  output logic              icache_ren,
  output logic              icache_abort,
  input  logic [W_DATA-1:0] icache_dout,
  input  logic              icache_dout_valid,
  input  logic              branch_valid,
  input  logic [W_ADDR-1:0] branch_target,
  input  logic              dispatch_ren,
  output logic [W_INSTR-1:0] ifq_inst,
  output logic [W_ADDR-1:0] ifq_pc,
  output logic              ifq_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WORDS = W_DATA / W_INSTR;

  logic [W_ADDR-1:0] fetch_pc;
  logic [W_ADDR-1:0] req_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [W_DATA-1:0] line_mem [DEPTH];
  logic [W_ADDR-1:0] pc_mem [DEPTH];

  logic [CW:0]       occupancy;
  logic              push;
  logic              pop;
  logic              free;
  logic [W_DATA-1:0] head_line;
  logic [W_ADDR-1:0] head_pc;
  logic [1:0]        head_word;

  // Credit counts both buffered lines and the read still in the icache pipe.
  assign occupancy    = (CW+1)'(count) + (CW+1)'(inflight);
  assign icache_ren   = !reset && !branch_valid && (occupancy < (CW+1)'(DEPTH));
  assign icache_pcout = fetch_pc;
  assign icache_abort = branch_valid;

  assign ifq_empty = (count == '0);
  assign head_line = line_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];
  assign head_word = head_pc[3:2];
  assign ifq_pc    = head_pc;

  assign push = icache_dout_valid && !branch_valid && !reset;
  assign pop  = dispatch_ren && !ifq_empty && !branch_valid && !reset;
  assign free = pop && (head_word == 2'd3);

  always_comb begin
    ifq_inst = head_line[W_INSTR-1:0];
    for (int i = 0; i < WORDS; i++) begin
      if (head_word == 2'(i)) ifq_inst = head_line[i*W_INSTR +: W_INSTR];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (branch_valid) begin
      fetch_pc <= branch_target & ~W_ADDR'(3);
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= icache_ren;
      if (icache_ren) begin
        req_pc   <= fetch_pc;
        fetch_pc <= {fetch_pc[W_ADDR-1:4] + (W_ADDR-4)'(1), 4'b0000};
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (free) rd_ptr <= rd_ptr + PW'(1);
      case ({push, free})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A partially consumed line stays in place; only its word index advances.
  always_ff @(posedge clk) begin
    if (pop && !free) pc_mem[rd_ptr][3:2] <= head_word + 2'd1;
    if (push) begin
      line_mem[wr_ptr] <= icache_dout;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a one-cycle-latency icache model whose
// line words encode their own address.
module tb_ifetch_queue;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  icache_pcout;
  logic         icache_ren;
  logic         icache_abort;
  logic [127:0] icache_dout;
  logic         icache_dout_valid;
  logic         branch_valid = 1'b0;
  logic [31:0]  branch_target = '0;
  logic         dispatch_ren = 1'b0;
  logic [31:0]  ifq_inst;
  logic [31:0]  ifq_pc;
  logic         ifq_empty;

  // Second instance only watches the fetch address wrap from the top of memory.
  logic [31:0]  w_pcout;
  logic         w_ren;
  logic         w_abort;
  logic [127:0] w_dout = '0;
  logic         w_dout_valid = 1'b0;
  logic         w_branch_valid = 1'b0;
  logic [31:0]  w_branch_target = '0;
  logic         w_dispatch_ren = 1'b0;
  logic [31:0]  w_inst;
  logic [31:0]  w_pc;
  logic         w_empty;

  int n_vec = 0;
  int n_err = 0;

  ifetch_queue #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .icache_pcout(icache_pcout), .icache_ren(icache_ren), .icache_abort(icache_abort),
    .icache_dout(icache_dout), .icache_dout_valid(icache_dout_valid),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .dispatch_ren(dispatch_ren),
    .ifq_inst(ifq_inst), .ifq_pc(ifq_pc), .ifq_empty(ifq_empty)
  );

  ifetch_queue #(.RESET_PC(32'hFFFF_FFF0)) dut_wrap (
    .clk(clk), .reset(reset),
    .icache_pcout(w_pcout), .icache_ren(w_ren), .icache_abort(w_abort),
    .icache_dout(w_dout), .icache_dout_valid(w_dout_valid),
    .branch_valid(w_branch_valid), .branch_target(w_branch_target),
    .dispatch_ren(w_dispatch_ren),
    .ifq_inst(w_inst), .ifq_pc(w_pc), .ifq_empty(w_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = inst_of({a[31:4], 4'b0000} + 32'(i * 4));
    return l;
  endfunction

  // Icache model: valid is deliberately not masked by abort, so the queue
  // itself must drop a line that lands in a redirect cycle.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  always_ff @(posedge clk) begin
    pend      <= icache_ren;
    pend_addr <= icache_pcout;
  end
  assign icache_dout_valid = pend;
  assign icache_dout       = make_line(pend_addr);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; branch_valid = 1'b0; dispatch_ren = 1'b0; #1;
    n_vec++; if (icache_ren !== 1'b0) begin n_err++; $display("FAIL rst_ren_high: got %0b want 0", icache_ren); end
    step();
    n_vec++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %0b want 1", ifq_empty); end
    n_vec++; if (icache_abort !== 1'b0) begin n_err++; $display("FAIL rst_abort: got %0b want 0", icache_abort); end
    n_vec++; if (icache_ren !== 1'b0) begin n_err++; $display("FAIL rst_ren_after_edge: got %0b want 0", icache_ren); end
    reset = 1'b0; #1;
  endtask

  task automatic test_cold_start;
    do_reset();
    dispatch_ren = 1'b1; #1;
    n_vec++; if (icache_ren !== 1'b1) begin n_err++; $display("FAIL cold_t0_ren: got %0b want 1", icache_ren); end
    n_vec++; if (icache_pcout !== 32'h0) begin n_err++; $display("FAIL cold_t0_pcout: got %h want 00000000", icache_pcout); end
    n_vec++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL cold_t0_empty: got %0b want 1", ifq_empty); end
    n_vec++; if (w_ren !== 1'b1 || w_pcout !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL wrap_t0: got ren=%0b pc=%h want ren=1 pc=fffffff0", w_ren, w_pcout); end
    step();
    n_vec++; if (icache_pcout !== 32'h10 || icache_ren !== 1'b1) begin n_err++; $display("FAIL cold_t1_issue: got ren=%0b pc=%h want ren=1 pc=00000010", icache_ren, icache_pcout); end
    n_vec++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL cold_t1_empty: got %0b want 1", ifq_empty); end
    n_vec++; if (w_ren !== 1'b1 || w_pcout !== 32'h0) begin n_err++; $display("FAIL wrap_t1: got ren=%0b pc=%h want ren=1 pc=00000000", w_ren, w_pcout); end
    step();
    n_vec++; if (icache_pcout !== 32'h20) begin n_err++; $display("FAIL cold_t2_pcout: got %h want 00000020", icache_pcout); end
    for (int k = 0; k < 12; k++) begin
      n_vec++; if (ifq_empty !== 1'b0 || ifq_pc !== 32'(k * 4)) begin n_err++; $display("FAIL cold_stream_pc[%0d]: got empty=%0b pc=%h want empty=0 pc=%h", k, ifq_empty, ifq_pc, 32'(k * 4)); end
      n_vec++; if (ifq_inst !== inst_of(32'(k * 4))) begin n_err++; $display("FAIL cold_stream_inst[%0d]: got %h want %h", k, ifq_inst, inst_of(32'(k * 4))); end
      step();
    end
    dispatch_ren = 1'b0;
  endtask

  task automatic test_backpressure;
    int issued;
    do_reset();
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      if (icache_ren === 1'b1) issued++;
      step();
    end
    n_vec++; if (issued !== 4) begin n_err++; $display("FAIL bp_issue_count: got %0d want 4", issued); end
    n_vec++; if (icache_ren !== 1'b0) begin n_err++; $display("FAIL bp_full_ren: got %0b want 0", icache_ren); end
    for (int w = 0; w < 4; w++) begin
      dispatch_ren = 1'b1; #1;
      n_vec++; if (ifq_pc !== 32'(w * 4) || icache_ren !== 1'b0) begin n_err++; $display("FAIL bp_word[%0d]: got pc=%h ren=%0b want pc=%h ren=0", w, ifq_pc, icache_ren, 32'(w * 4)); end
      step();
    end
    dispatch_ren = 1'b0; #1;
    n_vec++; if (icache_ren !== 1'b1 || icache_pcout !== 32'h40) begin n_err++; $display("FAIL bp_resume: got ren=%0b pc=%h want ren=1 pc=00000040", icache_ren, icache_pcout); end
    n_vec++; if (ifq_pc !== 32'h10) begin n_err++; $display("FAIL bp_next_head: got %h want 00000010", ifq_pc); end
    step();
    n_vec++; if (icache_ren !== 1'b0) begin n_err++; $display("FAIL bp_refull: got %0b want 0", icache_ren); end
  endtask

  task automatic test_redirect;
    do_reset();
    step();
    branch_valid = 1'b1; branch_target = 32'h0000_1238; #1;
    n_vec++; if (icache_abort !== 1'b1 || icache_ren !== 1'b0) begin n_err++; $display("FAIL redir_b: got abort=%0b ren=%0b want abort=1 ren=0", icache_abort, icache_ren); end
    step();
    branch_valid = 1'b0; #1;
    n_vec++; if (icache_abort !== 1'b0 || ifq_empty !== 1'b1) begin n_err++; $display("FAIL redir_b1_drop: got abort=%0b empty=%0b want abort=0 empty=1", icache_abort, ifq_empty); end
    n_vec++; if (icache_ren !== 1'b1 || icache_pcout !== 32'h1238) begin n_err++; $display("FAIL redir_b1_issue: got ren=%0b pc=%h want ren=1 pc=00001238", icache_ren, icache_pcout); end
    step();
    n_vec++; if (ifq_empty !== 1'b1 || icache_pcout !== 32'h1240) begin n_err++; $display("FAIL redir_b2: got empty=%0b pc=%h want empty=1 pc=00001240", ifq_empty, icache_pcout); end
    step();
    n_vec++; if (ifq_empty !== 1'b0 || ifq_pc !== 32'h1238) begin n_err++; $display("FAIL redir_b3_pc: got empty=%0b pc=%h want empty=0 pc=00001238", ifq_empty, ifq_pc); end
    n_vec++; if (ifq_inst !== inst_of(32'h1238)) begin n_err++; $display("FAIL redir_b3_inst: got %h want %h", ifq_inst, inst_of(32'h1238)); end
    dispatch_ren = 1'b1;
    step();
    n_vec++; if (ifq_pc !== 32'h123C) begin n_err++; $display("FAIL redir_pc2: got %h want 0000123c", ifq_pc); end
    step();
    n_vec++; if (ifq_pc !== 32'h1240 || ifq_inst !== inst_of(32'h1240)) begin n_err++; $display("FAIL redir_pc3: got pc=%h inst=%h want pc=00001240 inst=%h", ifq_pc, ifq_inst, inst_of(32'h1240)); end
    dispatch_ren = 1'b0;
  endtask

  task automatic test_branch_collision;
    do_reset();
    step(); step(); step();
    n_vec++; if (ifq_empty !== 1'b0 || ifq_pc !== 32'h0) begin n_err++; $display("FAIL coll_pre: got empty=%0b pc=%h want empty=0 pc=00000000", ifq_empty, ifq_pc); end
    branch_valid = 1'b1; branch_target = 32'h0000_2006; dispatch_ren = 1'b1; #1;
    n_vec++; if (icache_abort !== 1'b1 || icache_ren !== 1'b0) begin n_err++; $display("FAIL coll_b: got abort=%0b ren=%0b want abort=1 ren=0", icache_abort, icache_ren); end
    step();
    branch_valid = 1'b0; dispatch_ren = 1'b0; #1;
    n_vec++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL coll_flush: got empty=%0b want 1", ifq_empty); end
    n_vec++; if (icache_ren !== 1'b1 || icache_pcout !== 32'h2004) begin n_err++; $display("FAIL coll_target: got ren=%0b pc=%h want ren=1 pc=00002004", icache_ren, icache_pcout); end
    step(); step();
    n_vec++; if (ifq_empty !== 1'b0 || ifq_pc !== 32'h2004 || ifq_inst !== inst_of(32'h2004)) begin n_err++; $display("FAIL coll_first: got empty=%0b pc=%h inst=%h want empty=0 pc=00002004", ifq_empty, ifq_pc, ifq_inst); end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    step(); step(); step(); step();
    n_vec++; if (ifq_empty !== 1'b0) begin n_err++; $display("FAIL mid_pre_empty: got %0b want 0", ifq_empty); end
    do_reset();
    n_vec++; if (icache_ren !== 1'b1 || icache_pcout !== 32'h0) begin n_err++; $display("FAIL mid_restart: got ren=%0b pc=%h want ren=1 pc=00000000", icache_ren, icache_pcout); end
    n_vec++; if (ifq_empty !== 1'b1) begin n_err++; $display("FAIL mid_t0_empty: got %0b want 1", ifq_empty); end
    step(); step();
    n_vec++; if (ifq_empty !== 1'b0 || ifq_pc !== 32'h0) begin n_err++; $display("FAIL mid_t2: got empty=%0b pc=%h want empty=0 pc=00000000", ifq_empty, ifq_pc); end
  endtask

  initial begin
    test_cold_start();
    test_backpressure();
    test_redirect();
    test_branch_collision();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
